// File: rtl/xintf_bus_pkg.sv
// Shared constants, state encoding and helpers for the DSP external-bus initiator.
package xintf_bus_pkg;

  localparam int ADDR_W         = 11;
  localparam int DATA_W         = 16;
  localparam int PHASE_W        = 4;
  localparam int MIN_PHASE_CYC  = 1;
  localparam int MAX_PHASE_CYC  = 15;
  // Responder debounces strobes through two flops, so ACTIVE must outlast that.
  localparam int MIN_ACTIVE_CYC = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LEAD   = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_TRAIL  = 2'd3
  } bus_state_t;

  // Counter preload for a phase lasting 'cyc' clocks (terminal count at zero).
  function automatic logic [PHASE_W-1:0] phase_load(input int cyc);
    return PHASE_W'(cyc - 1);
  endfunction

endpackage

// File: rtl/xintf_phase_counter.sv
// Loadable down-counter shared by all bus phases; tc flags a count of zero.
module xintf_phase_counter
  import xintf_bus_pkg::*;
(
  input  logic               clk,
  input  logic               srst,
  input  logic               load,
  input  logic [PHASE_W-1:0] load_value,
  output logic [PHASE_W-1:0] count,
  output logic               tc
);

  // Load wins over counting; the count parks at zero until the next load.
  always_ff @(posedge clk) begin
    if (srst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - PHASE_W'(1);
    end
  end

  assign tc = (count == '0);

endmodule

// File: rtl/xintf_bus_master.sv
// Synchronous lead/active/trail initiator for the DSP external bus used to
// exercise CPLD decoders and latches without a DSP fitted.
module xintf_bus_master
  import xintf_bus_pkg::*;
#(
  parameter int LEAD_CYC   = 2,
  parameter int ACTIVE_CYC = 4,
  parameter int TRAIL_CYC  = 2
) (
  input  logic                clkDspIn,
  input  logic                dsp_reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  output logic [DATA_W-1:0]   rd_data,
  output logic                done,
  output logic [ADDR_W-1:0]   ab,
  output logic                re,
  output logic                we,
  output logic                xcs,
  output logic [DATA_W-1:0]   db_out,
  output logic                db_oe,
  input  logic [DATA_W-1:0]   db_in
);

  if (LEAD_CYC < MIN_PHASE_CYC || LEAD_CYC > MAX_PHASE_CYC) begin : g_bad_lead
    $error("LEAD_CYC out of range");
  end
  if (ACTIVE_CYC < MIN_ACTIVE_CYC || ACTIVE_CYC > MAX_PHASE_CYC) begin : g_bad_active
    $error("ACTIVE_CYC out of range");
  end
  if (TRAIL_CYC < MIN_PHASE_CYC || TRAIL_CYC > MAX_PHASE_CYC) begin : g_bad_trail
    $error("TRAIL_CYC out of range");
  end

  bus_state_t         state_reg;
  logic               wr_reg;
  logic [PHASE_W-1:0] cnt;
  logic               cnt_tc;
  logic               cnt_load;
  logic [PHASE_W-1:0] cnt_load_value;
  logic               accept;
  logic               trail_last_next;

  // cmd_ready is only ever high in IDLE or on the last TRAIL clock, so an
  // accept always means "start a new cycle" regardless of the current state.
  assign accept = cmd_valid & cmd_ready;

  // The next clock is the final TRAIL clock: done and cmd_ready go high there.
  assign trail_last_next = (state_reg == ST_ACTIVE && cnt_tc && TRAIL_CYC == 1) ||
                           (state_reg == ST_TRAIL && cnt == PHASE_W'(1));

  // Preload the shared counter on every phase entry.
  always_comb begin
    cnt_load       = 1'b0;
    cnt_load_value = '0;
    if (accept) begin
      cnt_load       = 1'b1;
      cnt_load_value = phase_load(LEAD_CYC);
    end else begin
      case (state_reg)
        ST_LEAD: if (cnt_tc) begin
          cnt_load       = 1'b1;
          cnt_load_value = phase_load(ACTIVE_CYC);
        end
        ST_ACTIVE: if (cnt_tc) begin
          cnt_load       = 1'b1;
          cnt_load_value = phase_load(TRAIL_CYC);
        end
        default: ;
      endcase
    end
  end

  xintf_phase_counter u_phase_counter (
    .clk        (clkDspIn),
    .srst       (dsp_reset),
    .load       (cnt_load),
    .load_value (cnt_load_value),
    .count      (cnt),
    .tc         (cnt_tc)
  );

  // Bus FSM; every output is registered and set for the state being entered.
  always_ff @(posedge clkDspIn) begin
    if (dsp_reset) begin
      state_reg <= ST_IDLE;
      wr_reg    <= 1'b0;
      cmd_ready <= 1'b0;
      rd_data   <= '0;
      done      <= 1'b0;
      ab        <= '0;
      re        <= 1'b1;
      we        <= 1'b1;
      xcs       <= 1'b1;
      db_out    <= '0;
      db_oe     <= 1'b0;
    end else begin
      done <= trail_last_next;
      if (accept) begin
        state_reg <= ST_LEAD;
        wr_reg    <= cmd_write;
        cmd_ready <= 1'b0;
        ab        <= cmd_addr;
        xcs       <= 1'b0;
        re        <= 1'b1;
        we        <= 1'b1;
        db_oe     <= cmd_write;
        if (cmd_write) begin
          db_out <= cmd_wdata;
        end
      end else begin
        case (state_reg)
          ST_IDLE: begin
            cmd_ready <= 1'b1;
          end
          ST_LEAD: begin
            cmd_ready <= 1'b0;
            if (cnt_tc) begin
              state_reg <= ST_ACTIVE;
              we        <= ~wr_reg;
              re        <= wr_reg;
            end
          end
          ST_ACTIVE: begin
            cmd_ready <= trail_last_next;
            if (cnt_tc) begin
              state_reg <= ST_TRAIL;
              we        <= 1'b1;
              re        <= 1'b1;
              if (!wr_reg) begin
                rd_data <= db_in;
              end
            end
          end
          ST_TRAIL: begin
            cmd_ready <= trail_last_next | cnt_tc;
            if (cnt_tc) begin
              state_reg <= ST_IDLE;
              xcs       <= 1'b1;
              db_oe     <= 1'b0;
            end
          end
          default: begin
            state_reg <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_xintf_bus_master.sv
// Directed bench for xintf_bus_master: default-timing instance plus an
// ACTIVE_CYC=3 instance driving a debounced set/reset latch responder.
module tb_xintf_bus_master;

  logic        clk = 1'b0;
  logic        dsp_reset;

  logic        cmd_valid, cmd_ready, cmd_write, done, re, we, xcs, db_oe;
  logic [10:0] cmd_addr, ab;
  logic [15:0] cmd_wdata, rd_data, db_out, db_in;

  logic        c_valid, c_ready, c_write, c_done, c_re, c_we, c_xcs, c_db_oe;
  logic [10:0] c_addr, c_ab;
  logic [15:0] c_wdata, c_rd_data, c_db_out, c_db_in;

  logic        latch_q, we_s1, we_s2, re_s1, re_s2;

  int checks = 0;
  int errors = 0;
  int got;

  always #5 clk = ~clk;

  xintf_bus_master dut (
    .clkDspIn(clk), .dsp_reset(dsp_reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .rd_data(rd_data),
    .done(done), .ab(ab), .re(re), .we(we), .xcs(xcs), .db_out(db_out), .db_oe(db_oe),
    .db_in(db_in)
  );

  xintf_bus_master #(.LEAD_CYC(2), .ACTIVE_CYC(3), .TRAIL_CYC(2)) dut3 (
    .clkDspIn(clk), .dsp_reset(dsp_reset), .cmd_valid(c_valid), .cmd_ready(c_ready),
    .cmd_write(c_write), .cmd_addr(c_addr), .cmd_wdata(c_wdata), .rd_data(c_rd_data),
    .done(c_done), .ab(c_ab), .re(c_re), .we(c_we), .xcs(c_xcs), .db_out(c_db_out),
    .db_oe(c_db_oe), .db_in(c_db_in)
  );

  // CPLD responder model: two-flop strobe debounce, latch at 0x400 set by write, cleared by read
  always_ff @(posedge clk) begin
    if (dsp_reset) begin
      we_s1 <= 1'b1; we_s2 <= 1'b1; re_s1 <= 1'b1; re_s2 <= 1'b1; latch_q <= 1'b0;
    end else begin
      we_s1 <= c_we; we_s2 <= we_s1; re_s1 <= c_re; re_s2 <= re_s1;
      if (!c_xcs && c_ab == 11'h400 && !we_s2) latch_q <= 1'b1;
      else if (!c_xcs && c_ab == 11'h400 && !re_s2) latch_q <= 1'b0;
    end
  end
  assign c_db_in = {15'd0, latch_q};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    dsp_reset = 1'b1;
    cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0; db_in = 16'hDEAD;
    c_valid = 0; c_write = 0; c_addr = '0; c_wdata = '0;
    repeat (3) @(negedge clk);

    // reset values
    check("rst_re", re, 1); check("rst_we", we, 1); check("rst_xcs", xcs, 1);
    check("rst_ab", ab, 0); check("rst_db_out", db_out, 0); check("rst_db_oe", db_oe, 0);
    check("rst_rd_data", rd_data, 0); check("rst_done", done, 0); check("rst_ready", cmd_ready, 0);
    check("rst_ready3", c_ready, 0);
    dsp_reset = 1'b0;
    @(negedge clk);
    check("ready_after_rst", cmd_ready, 1);

    // isolated write 0x402 / 0xA5A5
    cmd_valid = 1; cmd_write = 1; cmd_addr = 11'h402; cmd_wdata = 16'hA5A5;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k == 1) cmd_valid = 0;
      if (k <= 8) begin
        check($sformatf("wr_xcs_k%0d", k), xcs, 0);
        check($sformatf("wr_ab_k%0d", k), ab, 11'h402);
        check($sformatf("wr_oe_k%0d", k), db_oe, 1);
        check($sformatf("wr_dout_k%0d", k), db_out, 16'hA5A5);
        check($sformatf("wr_we_k%0d", k), we, (k >= 3 && k <= 6) ? 0 : 1);
        check($sformatf("wr_re_k%0d", k), re, 1);
        check($sformatf("wr_ready_k%0d", k), cmd_ready, (k == 8) ? 1 : 0);
      end else begin
        check("wr_idle_xcs", xcs, 1);
        check("wr_idle_oe", db_oe, 0);
        check("wr_idle_ready", cmd_ready, 1);
      end
      check($sformatf("wr_done_k%0d", k), done, (k == 8) ? 1 : 0);
    end

    // isolated read 0x405, db_in=0x1234 only around ACTIVE
    cmd_valid = 1; cmd_write = 0; cmd_addr = 11'h405; cmd_wdata = 16'h7777;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k == 1) cmd_valid = 0;
      if (k == 3) db_in = 16'h1234;
      if (k == 7) db_in = 16'hBEEF;
      if (k <= 8) begin
        check($sformatf("rd_xcs_k%0d", k), xcs, 0);
        check($sformatf("rd_ab_k%0d", k), ab, 11'h405);
        check($sformatf("rd_oe_k%0d", k), db_oe, 0);
        check($sformatf("rd_dout_k%0d", k), db_out, 16'hA5A5);
        check($sformatf("rd_re_k%0d", k), re, (k >= 3 && k <= 6) ? 0 : 1);
        check($sformatf("rd_we_k%0d", k), we, 1);
      end
      if (k >= 7) check($sformatf("rd_data_k%0d", k), rd_data, 16'h1234);
      check($sformatf("rd_done_k%0d", k), done, (k == 8) ? 1 : 0);
    end

    // back-to-back write 0x400 then read 0x401, valid held, inputs change mid-cycle
    cmd_valid = 1; cmd_write = 1; cmd_addr = 11'h400; cmd_wdata = 16'h1111;
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      if (k == 1) begin cmd_write = 0; cmd_addr = 11'h401; cmd_wdata = 16'h2222; end
      if (k == 9) cmd_valid = 0;
      check($sformatf("b2b_xcs_k%0d", k), xcs, (k <= 16) ? 0 : 1);
      if (k <= 16) check($sformatf("b2b_ab_k%0d", k), ab, (k <= 8) ? 11'h400 : 11'h401);
      check($sformatf("b2b_oe_k%0d", k), db_oe, (k <= 8) ? 1 : 0);
      check($sformatf("b2b_dout_k%0d", k), db_out, 16'h1111);
      check($sformatf("b2b_we_k%0d", k), we, (k >= 3 && k <= 6) ? 0 : 1);
      check($sformatf("b2b_re_k%0d", k), re, (k >= 11 && k <= 14) ? 0 : 1);
      check($sformatf("b2b_done_k%0d", k), done, (k == 8 || k == 16) ? 1 : 0);
      check($sformatf("b2b_ready_k%0d", k), cmd_ready, (k == 8 || k == 16 || k == 17) ? 1 : 0);
    end

    // reset during second ACTIVE clock of a write
    cmd_valid = 1; cmd_write = 1; cmd_addr = 11'h403; cmd_wdata = 16'h5A5A;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) cmd_valid = 0;
      if (k == 4) begin
        check("abort_we_low", we, 0);
        dsp_reset = 1'b1;
      end
      if (k == 5) begin
        check("abort_we", we, 1); check("abort_xcs", xcs, 1); check("abort_ab", ab, 0);
        check("abort_oe", db_oe, 0); check("abort_dout", db_out, 0);
        check("abort_rd_data", rd_data, 0); check("abort_ready", cmd_ready, 0);
        dsp_reset = 1'b0;
      end
      if (k == 6) check("abort_ready_back", cmd_ready, 1);
      if (k >= 5) begin
        check($sformatf("abort_done_k%0d", k), done, 0);
        check($sformatf("abort_xcs_k%0d", k), xcs, 1);
      end
    end

    // ACTIVE_CYC=3 instance against the latch responder
    check("latch_init", latch_q, 0);
    c_valid = 1; c_write = 1; c_addr = 11'h400; c_wdata = 16'h0001;
    got = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) c_valid = 0;
      check($sformatf("a3_wr_both_low_k%0d", k), {c_we, c_re} == 2'b00, 0);
      if (c_done) begin got = k; break; end
    end
    check("a3_wr_done_at", got, 7);
    check("a3_latch_set", latch_q, 1);

    @(negedge clk);
    c_valid = 1; c_write = 0; c_addr = 11'h400;
    got = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) c_valid = 0;
      if (c_done) begin got = k; break; end
    end
    check("a3_rd_done_at", got, 7);
    check("a3_rd_data", c_rd_data, 16'h0001);
    check("a3_latch_clr", latch_q, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/xintf_bus_master.md
# xintf_bus_master

Synchronous initiator for the DSP external-bus protocol used on the TB3 boards. It generates lead/active/trail cycles on an 11-bit address bus (DSP address bits [18:8]), active-low RE/WE strobes, an active-low chip select (XZCS2 equivalent) and a 16-bit data bus. It sits in FPGA test/bring-up logic so that the CPLD address decoders, set/reset latches and async mux outputs can be exercised without a DSP.

## Interface
- LEAD_CYC, 2: clocks in lead phase, range 1..15.
- ACTIVE_CYC, 4: clocks in active phase, range 3..15. The minimum of 3 covers the responder's two-stage strobe debounce.
- TRAIL_CYC, 2: clocks in trail phase, range 1..15.
- clkDspIn  in  1  sole clock; all logic on rising edge.
- dsp_reset  in  1  reset, synchronous, active-high.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted on a clock with valid&ready.
- cmd_write  in  1  1 = write cycle, 0 = read cycle.
- cmd_addr  in  11  bus address [18:8].
- cmd_wdata  in  16  write data.
- rd_data  out  16  captured read data.
- done  out  1  one-clock pulse at end of trail.
- ab  out  11  address bus.
- re  out  1  read strobe, active low.
- we  out  1  write strobe, active low.
- xcs  out  1  chip select, active low.
- db_out  out  16  data bus drive value.
- db_oe  out  1  data bus output enable.
- db_in  in  16  data bus sampled value.

## Operation
- States: IDLE, LEAD, ACTIVE, TRAIL.
- IDLE:
  - cmd_ready=1.
  - On accept, latch write/addr/wdata into registers, then go to LEAD.
- LEAD:
  - ab=latched addr; xcs=0; re=we=1.
  - In a write, db_oe=1 and db_out=wdata.
  - Lasts LEAD_CYC clocks, then goes to ACTIVE.
- ACTIVE:
  - Same as LEAD, plus we=0 (write) or re=0 (read).
  - Lasts ACTIVE_CYC clocks.
  - In a read, rd_data <= db_in on the last ACTIVE clock.
- TRAIL:
  - Strobes high. xcs=0, ab held. db_oe held for writes (hold time).
  - Lasts TRAIL_CYC clocks.
  - On the last clock, done=1.
  - Next state: LEAD if a new command is accepted that clock, otherwise IDLE.
- cmd_ready is 1 in IDLE and on the last TRAIL clock, and 0 otherwise. This makes back-to-back cycles gapless: xcs stays 0, and ab changes only at the LEAD boundary.
- cmd_valid while not ready: ignored and not stored. The requester holds it.
- A single phase down-counter is loaded with PHASE_CYC-1 on entry to each phase; the phase ends when the count reaches 0.
- Read cycles: db_oe=0 throughout. db_out holds its last value.

## Timing
- Reset values, while dsp_reset=1 and on the first clock after it: state=IDLE, re=we=xcs=1, ab=0, db_out=0, db_oe=0, rd_data=0, done=0, cmd_ready=0.
- cmd_ready rises on the first clock after reset deasserts.
- All bus outputs are registered, with no combinational path from cmd_* to the bus.
- Accept at edge N: xcs=0 and ab valid from N+1.
- Strobe low for exactly ACTIVE_CYC clocks, starting at N+1+LEAD_CYC.
- done pulses at N+LEAD_CYC+ACTIVE_CYC+TRAIL_CYC.
- rd_data is valid in the same clock as done and holds until the next read completes.
- Total cycle length: LEAD_CYC+ACTIVE_CYC+TRAIL_CYC clocks. Isolated commands add one IDLE clock.
- Reset mid-cycle:
  - On the next edge, all outputs return to reset values with no partial strobe extension.
  - The aborted command is lost and does not pulse done.
- re and we are never low simultaneously. A strobe is never low outside ACTIVE.

## Structure
- Shared package xintf_bus_pkg:
  - State encoding.
  - ADDR_W=11, DATA_W=16.
  - MIN_ACTIVE_CYC=3.
  - Phase-count width 4.
- Parameter range checks are elaboration-time assertions against the package constants.
- Sub-module xintf_phase_counter: 4-bit loadable down-counter with a terminal-count flag. It is instantiated once and shared by all phases.

## Test plan
- Write to 0x402, wdata 0xA5A5, default parameters:
  - xcs low for 8 clocks.
  - we low for exactly 4 clocks, starting 3 clocks after accept.
  - ab=0x402 and db_oe=1 for all 8 clocks.
  - done at clock 8.
- Read from 0x405 with db_in=0x1234 during ACTIVE:
  - re low for 4 clocks, db_oe=0 throughout.
  - rd_data=0x1234 when done pulses.
- Back-to-back write 0x400 then read 0x401 with cmd_valid held:
  - xcs stays low for 16 clocks.
  - ab switches 0x400→0x401 at the LEAD boundary.
  - Two done pulses, 8 clocks apart.
- dsp_reset asserted during the second ACTIVE clock of a write:
  - Next clock: we=1, xcs=1, ab=0, db_oe=0, no done.
  - cmd_ready=1 one clock after reset deasserts.
- cmd_valid held high with changing cmd_addr mid-cycle:
  - Address and data latched at accept are unchanged on the bus.
  - The second command is accepted only on the last TRAIL clock.
- ACTIVE_CYC=3 driving a CPLD responder model (set on write, reset on read at address 0x400):
  - Write sets the latch output to 1.
  - Subsequent read clears it to 0.
